// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: execute-stage issue and writeback controller.
//
// Accepts decoded operations from ID over a valid/ready handshake. ALU
// operations are written back one cycle after acceptance through a
// registered write port. MDU operations are started with a single-cycle
// pulse and tracked until the MDU reports done, a flush kills them, or a
// timeout expires. While an MDU operation is outstanding, ID is stalled on
// a second MDU operation (structural hazard) and on any operation whose
// rs1/rs2/rd matches the pending MDU destination (RAW/WAW hazard).
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   issue_valid_i / issue_ready_o   ID handshake
//   issue_is_mdu_i                  1 = MDU op, 0 = ALU op
//   issue_rs1/rs2/rd_addr_i         register addresses of the offered op
//   alu_we_i/alu_wr_addr_i/alu_wdata_i  combinational ALU result
//   mdu_start_o, mdu_kill_o         MDU control pulses
//   mdu_done_i, mdu_wdata_i         MDU completion and result
//   flush_i                         pipeline flush
//   wb_we_o/wb_addr_o/wb_wdata_o    registered register-file write port
//   mdu_busy_o                      MDU operation outstanding
//   err_o                           sticky MDU timeout error
module ex_issue_ctrl #(
  parameter int MDU_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic        issue_is_mdu_i,
  input  logic [4:0]  issue_rs1_addr_i,
  input  logic [4:0]  issue_rs2_addr_i,
  input  logic [4:0]  issue_rd_addr_i,
  input  logic        alu_we_i,
  input  logic [4:0]  alu_wr_addr_i,
  input  logic [31:0] alu_wdata_i,
  output logic        mdu_start_o,
  output logic        mdu_kill_o,
  input  logic        mdu_done_i,
  input  logic [31:0] mdu_wdata_i,
  input  logic        flush_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_wdata_o,
  output logic        mdu_busy_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(MDU_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [4:0]       pend_rd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             wb_we_reg;
  logic [4:0]       wb_addr_reg;
  logic [31:0]      wb_wdata_reg;
  logic             err_reg;

  logic             busy;
  logic [2:0]       addr_hit;
  logic             hazard;
  logic             ready;
  logic             accept;
  logic             done_take;
  logic             timeout_hit;

  // Hazard compare of the pending destination against each address of the
  // offered operation (rs1, rs2, rd).
  logic [4:0] src_addr [3];
  assign src_addr[0] = issue_rs1_addr_i;
  assign src_addr[1] = issue_rs2_addr_i;
  assign src_addr[2] = issue_rd_addr_i;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      assign addr_hit[gi] = (src_addr[gi] == pend_rd_reg);
    end
  endgenerate

  assign busy   = (state_reg == BUSY);
  // x0 is never a real dependency, so a pending write to x0 blocks nothing.
  assign hazard = busy && (pend_rd_reg != 5'd0) && (|addr_hit);

  // mdu_done_i reserves the write port, so an ALU accept never collides
  // with an MDU writeback in the same cycle.
  assign ready  = !rst_i && !flush_i && !mdu_done_i &&
                  !(busy && issue_is_mdu_i) && !hazard;
  assign accept = issue_valid_i && ready;

  // A flush discards a coincident done; a done beats a coincident timeout.
  assign done_take   = busy && mdu_done_i && !flush_i;
  assign timeout_hit = busy && !mdu_done_i && (cnt_reg == CNT_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && issue_is_mdu_i) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (flush_i || mdu_done_i || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    issue_ready_o = ready;
    mdu_start_o   = accept && issue_is_mdu_i;
    // Reset drops an outstanding op silently, hence the rst_i gate.
    mdu_kill_o    = !rst_i && busy && (flush_i || timeout_hit);
    mdu_busy_o    = busy;
  end

  // Pending destination, timeout counter, writeback port and error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_rd_reg  <= 5'd0;
      cnt_reg      <= '0;
      wb_we_reg    <= 1'b0;
      wb_addr_reg  <= 5'd0;
      wb_wdata_reg <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      wb_we_reg <= 1'b0;
      if (done_take) begin
        wb_we_reg    <= (pend_rd_reg != 5'd0);
        wb_addr_reg  <= pend_rd_reg;
        wb_wdata_reg <= mdu_wdata_i;
      end else if (accept && !issue_is_mdu_i) begin
        wb_we_reg    <= alu_we_i && (alu_wr_addr_i != 5'd0);
        wb_addr_reg  <= alu_wr_addr_i;
        wb_wdata_reg <= alu_wdata_i;
      end

      if (accept && issue_is_mdu_i) begin
        pend_rd_reg <= issue_rd_addr_i;
        cnt_reg     <= '0;
      end else if (busy && !mdu_done_i && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign wb_we_o    = wb_we_reg;
  assign wb_addr_o  = wb_addr_reg;
  assign wb_wdata_o = wb_wdata_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed testbench for ex_issue_ctrl (MDU_TIMEOUT = 8).
module tb_ex_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_is_mdu;
  logic [4:0]  rs1, rs2, rd;
  logic        alu_we;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wdata;
  logic        mdu_start;
  logic        mdu_kill;
  logic        mdu_done;
  logic [31:0] mdu_wdata;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        mdu_busy;
  logic        err;

  int passed = 0;
  int total  = 0;

  ex_issue_ctrl #(.MDU_TIMEOUT(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_is_mdu_i   (issue_is_mdu),
    .issue_rs1_addr_i (rs1),
    .issue_rs2_addr_i (rs2),
    .issue_rd_addr_i  (rd),
    .alu_we_i         (alu_we),
    .alu_wr_addr_i    (alu_wr_addr),
    .alu_wdata_i      (alu_wdata),
    .mdu_start_o      (mdu_start),
    .mdu_kill_o       (mdu_kill),
    .mdu_done_i       (mdu_done),
    .mdu_wdata_i      (mdu_wdata),
    .flush_i          (flush),
    .wb_we_o          (wb_we),
    .wb_addr_o        (wb_addr),
    .wb_wdata_o       (wb_wdata),
    .mdu_busy_o       (mdu_busy),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid  = 1'b0;
    issue_is_mdu = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    alu_we = 1'b0; alu_wr_addr = 5'd0; alu_wdata = 32'd0;
    mdu_done = 1'b0; mdu_wdata = 32'd0;
    flush = 1'b0;
  endtask

  task automatic offer(input logic is_mdu, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic [31:0] data);
    issue_valid  = 1'b1;
    issue_is_mdu = is_mdu;
    rs1 = a1; rs2 = a2; rd = d;
    alu_we      = !is_mdu;
    alu_wr_addr = d;
    alu_wdata   = data;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    // Reset: even with an offered MDU op, nothing is accepted or started.
    @(negedge clk);
    offer(1'b1, 5'd0, 5'd0, 5'd4, 32'd0);
    #1;
    chk("rst_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_start", {31'd0, mdu_start}, 32'd0);
    chk("rst_kill",  {31'd0, mdu_kill}, 32'd0);
    tick();
    tick();
    chk("rst_wb_we",   {31'd0, wb_we}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_wdata, 32'd0);
    chk("rst_busy",    {31'd0, mdu_busy}, 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    rst = 1'b0;
    idle_in();
    tick();

    // ALU op rd=5 -> write of 0xAA one cycle later
    offer(1'b0, 5'd1, 5'd2, 5'd5, 32'h0000_00AA);
    #1;
    chk("alu_ready", {31'd0, issue_ready}, 32'd1);
    chk("alu_start", {31'd0, mdu_start}, 32'd0);
    tick();
    idle_in();
    #1;
    chk("alu_wb_we",   {31'd0, wb_we}, 32'd1);
    chk("alu_wb_addr", {27'd0, wb_addr}, 32'd5);
    chk("alu_wb_data", wb_wdata, 32'h0000_00AA);
    // Same op to x0 -> no write
    offer(1'b0, 5'd1, 5'd2, 5'd0, 32'h0000_00AA);
    tick();
    idle_in();
    #1;
    chk("alu_x0_we", {31'd0, wb_we}, 32'd0);

    // MDU rd=7, dependent ALU op stalls until done
    offer(1'b1, 5'd0, 5'd0, 5'd7, 32'd0);
    #1;
    chk("mdu_ready", {31'd0, issue_ready}, 32'd1);
    chk("mdu_start", {31'd0, mdu_start}, 32'd1);
    tick();
    offer(1'b0, 5'd7, 5'd0, 5'd9, 32'h0000_0055);
    #1;
    chk("raw_busy",   {31'd0, mdu_busy}, 32'd1);
    chk("raw_c1_rdy", {31'd0, issue_ready}, 32'd0);
    chk("raw_c1_st",  {31'd0, mdu_start}, 32'd0);
    tick();
    chk("raw_c2_rdy", {31'd0, issue_ready}, 32'd0);
    tick();
    mdu_done  = 1'b1;
    mdu_wdata = 32'h0000_1234;
    #1;
    chk("raw_c3_rdy", {31'd0, issue_ready}, 32'd0);
    tick();
    mdu_done  = 1'b0;
    mdu_wdata = 32'd0;
    #1;
    chk("mdu_wb_we",   {31'd0, wb_we}, 32'd1);
    chk("mdu_wb_addr", {27'd0, wb_addr}, 32'd7);
    chk("mdu_wb_data", wb_wdata, 32'h0000_1234);
    chk("mdu_idle",    {31'd0, mdu_busy}, 32'd0);
    chk("raw_c4_rdy",  {31'd0, issue_ready}, 32'd1);
    tick();
    idle_in();
    #1;
    chk("raw_alu_we",   {31'd0, wb_we}, 32'd1);
    chk("raw_alu_addr", {27'd0, wb_addr}, 32'd9);
    chk("raw_alu_data", wb_wdata, 32'h0000_0055);
    tick();
    chk("hold_we",   {31'd0, wb_we}, 32'd0);
    chk("hold_addr", {27'd0, wb_addr}, 32'd9);
    chk("hold_data", wb_wdata, 32'h0000_0055);

    // While BUSY: second MDU stalls, independent ALU passes, WAW on rd stalls
    offer(1'b1, 5'd0, 5'd0, 5'd10, 32'd0);
    tick();
    offer(1'b1, 5'd0, 5'd0, 5'd11, 32'd0);
    #1;
    chk("struct_rdy",   {31'd0, issue_ready}, 32'd0);
    chk("struct_start", {31'd0, mdu_start}, 32'd0);
    offer(1'b0, 5'd1, 5'd2, 5'd3, 32'h0000_0033);
    #1;
    chk("indep_rdy", {31'd0, issue_ready}, 32'd1);
    tick();
    offer(1'b0, 5'd0, 5'd0, 5'd10, 32'h0000_0044);
    #1;
    chk("indep_we",   {31'd0, wb_we}, 32'd1);
    chk("indep_addr", {27'd0, wb_addr}, 32'd3);
    chk("indep_data", wb_wdata, 32'h0000_0033);
    chk("indep_busy", {31'd0, mdu_busy}, 32'd1);
    chk("waw_rdy",    {31'd0, issue_ready}, 32'd0);
    offer(1'b0, 5'd0, 5'd10, 5'd3, 32'h0000_0044);
    #1;
    chk("raw_rs2_rdy", {31'd0, issue_ready}, 32'd0);
    idle_in();
    mdu_done  = 1'b1;
    mdu_wdata = 32'h0000_ABCD;
    tick();
    idle_in();
    #1;
    chk("b_wb_addr", {27'd0, wb_addr}, 32'd10);
    chk("b_wb_data", wb_wdata, 32'h0000_ABCD);

    // Registered ALU write still completes during a flush; flush in BUSY
    // with a coincident done kills and discards the result.
    offer(1'b0, 5'd0, 5'd0, 5'd6, 32'h0000_0066);
    tick();
    idle_in();
    flush = 1'b1;
    #1;
    chk("flush_prev_we", {31'd0, wb_we}, 32'd1);
    chk("flush_rdy",     {31'd0, issue_ready}, 32'd0);
    tick();
    idle_in();
    offer(1'b1, 5'd0, 5'd0, 5'd12, 32'd0);
    tick();
    idle_in();
    flush     = 1'b1;
    mdu_done  = 1'b1;
    mdu_wdata = 32'h0000_DEAD;
    #1;
    chk("flush_kill", {31'd0, mdu_kill}, 32'd1);
    tick();
    idle_in();
    #1;
    chk("flush_wb_we", {31'd0, wb_we}, 32'd0);
    chk("flush_busy",  {31'd0, mdu_busy}, 32'd0);
    chk("flush_kill0", {31'd0, mdu_kill}, 32'd0);

    // Timeout: start in cycle S, kill in S+8, err from S+9
    offer(1'b1, 5'd0, 5'd0, 5'd13, 32'd0);
    #1;
    chk("to_start", {31'd0, mdu_start}, 32'd1);
    tick();
    idle_in();
    for (int k = 1; k < 8; k++) begin
      #1;
      chk($sformatf("to_kill_c%0d", k), {31'd0, mdu_kill}, 32'd0);
      chk($sformatf("to_busy_c%0d", k), {31'd0, mdu_busy}, 32'd1);
      tick();
    end
    chk("to_err_pre", {31'd0, err}, 32'd0);
    chk("to_kill",    {31'd0, mdu_kill}, 32'd1);
    tick();
    chk("to_err",   {31'd0, err}, 32'd1);
    chk("to_busy",  {31'd0, mdu_busy}, 32'd0);
    chk("to_kill0", {31'd0, mdu_kill}, 32'd0);
    chk("to_wb_we", {31'd0, wb_we}, 32'd0);
    offer(1'b0, 5'd0, 5'd0, 5'd8, 32'h0000_0088);
    tick();
    idle_in();
    tick();
    tick();
    chk("to_err_sticky", {31'd0, err}, 32'd1);

    // Reset while BUSY: silent drop, later stray done ignored
    offer(1'b1, 5'd0, 5'd0, 5'd14, 32'd0);
    tick();
    idle_in();
    rst = 1'b1;
    #1;
    chk("rb_kill",  {31'd0, mdu_kill}, 32'd0);
    chk("rb_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rb_busy",    {31'd0, mdu_busy}, 32'd0);
    chk("rb_err",     {31'd0, err}, 32'd0);
    chk("rb_wb_we",   {31'd0, wb_we}, 32'd0);
    chk("rb_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rb_wb_data", wb_wdata, 32'd0);
    chk("rb_kill0",   {31'd0, mdu_kill}, 32'd0);
    tick();
    mdu_done  = 1'b1;
    mdu_wdata = 32'h0000_BEEF;
    tick();
    idle_in();
    #1;
    chk("stray_wb_we",   {31'd0, wb_we}, 32'd0);
    chk("stray_wb_data", wb_wdata, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
